sm_reg_fifo: RTL and testbench
==============================

SM_REG_FIFO -- requirements
Module: sm_reg_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1 or more.
REQ-002 Parameter DEPTH, default 4: number of entries, a power of two, 2 or more.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 we  input  1  write request; pushes wd when accepted.
REQ-006 wd  input  WIDTH  write data.
REQ-007 re  input  1  read request; pops the head entry when accepted.
REQ-008 rd  output  WIDTH  head entry (show-ahead); valid while empty=0.
REQ-009 full  output  1  high when count==DEPTH.
REQ-010 empty  output  1  high when count==0.
REQ-011 count  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-012 err  output  1  sticky overflow/underflow flag; present only with SM_FIFO_ERR_EN (REQ-030).

Function
REQ-013 Storage SHALL be DEPTH registers of WIDTH bits, a write pointer and a read pointer, each log2(DEPTH) bits wide, plus a count register.
REQ-014 A write SHALL be accepted when we=1 and (full=0, or re=1 with full=1); an accepted write stores wd at the write pointer, and the pointer increments modulo DEPTH.
REQ-015 A read SHALL be accepted when re=1 and empty=0; an accepted read increments the read pointer modulo DEPTH.
REQ-016 rd SHALL be combinational from the entry at the read pointer, so data is visible in the same cycle as empty=0 (zero-latency show-ahead); rd SHALL be all zeros while empty=1.
REQ-017 A word written at edge N SHALL appear on rd after edge N if the FIFO was empty, giving a write-to-read latency of one clock.
REQ-018 count SHALL change as follows: +1 on a write alone, -1 on a read alone, unchanged on both or neither.
REQ-019 full, empty SHALL be decoded from the count register only, with no combinational path from we/re.
REQ-020 Full with we=1 and re=1: both SHALL be accepted, count stays DEPTH, and the head is replaced by the next entry.
REQ-021 Empty with we=1 and re=1: the write SHALL be accepted, the read ignored, and count becomes 1.
REQ-022 we=1 while full and re=0: the write SHALL be dropped, with storage, pointers and count unchanged.
REQ-023 re=1 while empty and we=0: the read SHALL be ignored, with no state change.
REQ-024 Pointer wrap-around from DEPTH-1 to 0 SHALL be seamless, preserving FIFO order.

Reset
REQ-025 While rst=0, pointers, count and all storage registers SHALL clear to zero asynchronously.
REQ-026 Reset values SHALL be empty=1, full=0, count=0, rd=0, and err=0 when present.
REQ-027 Reset asserted mid-operation SHALL discard all stored data; the first edge after release SHALL behave as from the empty state.
REQ-028 The design SHALL need no synchronous initialisation after reset release.

Configuration
REQ-029 Macro SM_FIFO_ERR_EN SHALL control the err port and its logic.
REQ-030 When SM_FIFO_ERR_EN is defined, err SHALL set on the edge following a dropped write (REQ-022) or an ignored read (REQ-023), hold until reset, and never affect data path behaviour.
REQ-031 When SM_FIFO_ERR_EN is undefined, the err port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then idle for 3 cycles -> empty=1, full=0, count=0, rd=0 throughout.
REQ-033 DEPTH=4: write 0x11,0x22,0x33,0x44 on consecutive cycles -> full=1, count=4; then read 4 cycles -> rd sequence 0x11,0x22,0x33,0x44, then empty=1.
REQ-034 Full with 0xA0..0xA3 stored: we=1 wd=0xB0 re=1 for one cycle -> count=4, rd=0xA1, and 0xB0 is read last.
REQ-035 Empty: we=1 wd=0x5C re=1 -> count=1, rd=0x5C; full with we=1 re=0 wd=0xEE -> contents unchanged, err=1 when SM_FIFO_ERR_EN is defined.
REQ-036 Stream 10 words 0x00..0x09 with random we/re gaps, across 2 wraps -> output order equals input order and count never exceeds 4.
REQ-037 Assert rst with count=3 -> outputs reach reset values immediately; a write of 0x77 after release -> rd=0x77, count=1.

Source files
------------

// File: rtl/sm_reg_fifo_if.sv
// Handshake bundle between a FIFO user (master) and sm_reg_fifo (slave).
// Latency: none, wires only.
// Backpressure: the master watches full/empty and the FIFO drops unacceptable requests.
// Signals: we/wd write request and data, re read request, rd show-ahead head word,
// full/empty/count occupancy, err sticky drop flag (only with SM_FIFO_ERR_EN).
interface sm_reg_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             we;
    logic [WIDTH-1:0] wd;
    logic             re;
    logic [WIDTH-1:0] rd;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;

`ifdef SM_FIFO_ERR_EN
    logic             err;

    modport master (output we, wd, re, input rd, full, empty, count, err);
    modport slave  (input we, wd, re, output rd, full, empty, count, err);
`else
    modport master (output we, wd, re, input rd, full, empty, count);
    modport slave  (input we, wd, re, output rd, full, empty, count);
`endif
endinterface

// File: rtl/sm_reg_fifo.sv
// Register-based show-ahead FIFO of DEPTH words of WIDTH bits.
// Latency: one clock from an accepted write into an empty FIFO to the word on rd.
// Backpressure: a write while full is dropped unless a read is accepted in the same cycle, and a read while empty is ignored.
// Ports: clk, rst (async, active-low), bus (sm_reg_fifo_if.slave).
// Build option: SM_FIFO_ERR_EN adds the sticky err output, which sets after a dropped write or an ignored read.
module sm_reg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    sm_reg_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             full_i;
    logic             empty_i;
    logic             wr_acc;
    logic             rd_acc;

    // Status comes from the count register only, so there is no path from we/re.
    assign full_i  = (cnt == CW'(DEPTH));
    assign empty_i = (cnt == '0);

    // When the FIFO is full, a simultaneous read frees the slot the write needs.
    assign wr_acc = bus.we && (!full_i || bus.re);
    assign rd_acc = bus.re && !empty_i;

    assign bus.full  = full_i;
    assign bus.empty = empty_i;
    assign bus.count = cnt;
    assign bus.rd    = empty_i ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= bus.wd;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef SM_FIFO_ERR_EN
    logic err_q;

    // A read into an empty FIFO that carries a write is a normal case, not an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((bus.we && full_i && !bus.re) || (bus.re && empty_i && !bus.we)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_sm_reg_fifo.sv
module tb_sm_reg_fifo;
    logic clk;
    logic rst;

    sm_reg_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    sm_reg_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a plain queue holding the stored words in arrival order.
    logic [7:0] q[$];
`ifdef SM_FIFO_ERR_EN
    logic m_err = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] m_head();
        return (q.size() > 0) ? q[0] : 8'h00;
    endfunction

    // Drive one cycle of requests, let the edge happen, then advance the model.
    task automatic step(input logic w, input logic [7:0] d, input logic r);
        bit wa;
        bit ra;
        bus.we = w;
        bus.wd = d;
        bus.re = r;
        wa = w && (q.size() < 4 || r);
        ra = r && (q.size() > 0);
`ifdef SM_FIFO_ERR_EN
        if ((w && q.size() == 4 && !r) || (r && q.size() == 0 && !w)) m_err = 1'b1;
`endif
        @(posedge clk);
        #1;
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(d);
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    task automatic test_reset();
        bus.we = 1'b0;
        bus.re = 1'b0;
        bus.wd = 8'h00;
        rst = 1'b0;
        q.delete();
        #12;
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 3'd0 || bus.rd !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_hold: empty=%b full=%b count=%0d rd=%h, required 1 0 0 00",
                     bus.empty, bus.full, bus.count, bus.rd);
        end
`ifdef SM_FIFO_ERR_EN
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: err=%b, required 0", bus.err);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            n_cmp++;
            if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 3'd0 || bus.rd !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_idle%0d: empty=%b full=%b count=%0d rd=%h, required 1 0 0 00",
                         i, bus.empty, bus.full, bus.count, bus.rd);
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) step(1'b1, vals[i], 1'b0);
        n_cmp++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4 || bus.empty !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_status: full=%b count=%0d empty=%b, required 1 4 0",
                     bus.full, bus.count, bus.empty);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.rd !== vals[i]) begin
                n_bad++;
                $display("FAIL drain_rd%0d: rd=%h, required %h", i, bus.rd, vals[i]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.count !== 3'd0 || bus.rd !== 8'h00) begin
            n_bad++;
            $display("FAIL drain_empty: empty=%b count=%0d rd=%h, required 1 0 00",
                     bus.empty, bus.count, bus.rd);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_seq [4];
        for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0);
        step(1'b1, 8'hB0, 1'b1);
        n_cmp++;
        if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.rd !== 8'hA1) begin
            n_bad++;
            $display("FAIL full_rw: count=%0d full=%b rd=%h, required 4 1 a1",
                     bus.count, bus.full, bus.rd);
        end
        exp_seq[0] = 8'hA1; exp_seq[1] = 8'hA2; exp_seq[2] = 8'hA3; exp_seq[3] = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.rd !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL full_rw_order%0d: rd=%h, required %h", i, bus.rd, exp_seq[i]);
            end
            step(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_empty_rw_and_drops();
        step(1'b1, 8'h5C, 1'b1);
        n_cmp++;
        if (bus.count !== 3'd1 || bus.rd !== 8'h5C || bus.empty !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_rw: count=%0d rd=%h empty=%b, required 1 5c 0",
                     bus.count, bus.rd, bus.empty);
        end
`ifdef SM_FIFO_ERR_EN
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_rw_err: err=%b, required 0", bus.err);
        end
`endif
        step(1'b0, 8'h00, 1'b1);
        // Ignored read on an empty FIFO.
        step(1'b0, 8'h00, 1'b1);
        n_cmp++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.rd !== 8'h00) begin
            n_bad++;
            $display("FAIL underflow: count=%0d empty=%b rd=%h, required 0 1 00",
                     bus.count, bus.empty, bus.rd);
        end
`ifdef SM_FIFO_ERR_EN
        n_cmp++;
        if (bus.err !== m_err) begin
            n_bad++;
            $display("FAIL underflow_err: err=%b, required %b", bus.err, m_err);
        end
`endif
        for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        n_cmp++;
        if (bus.count !== 3'd4 || bus.rd !== 8'hC0) begin
            n_bad++;
            $display("FAIL overflow: count=%0d rd=%h, required 4 c0", bus.count, bus.rd);
        end
`ifdef SM_FIFO_ERR_EN
        n_cmp++;
        if (bus.err !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_err: err=%b, required 1", bus.err);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.rd !== 8'hC0 + 8'(i)) begin
                n_bad++;
                $display("FAIL overflow_keep%0d: rd=%h, required %h", i, bus.rd, 8'hC0 + 8'(i));
            end
            step(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_stream();
        int next_wr = 0;
        int next_rd = 0;
        int cyc = 0;
        logic w;
        logic r;
        bit wa;
        while (next_rd < 10 && cyc < 400) begin
            w = (next_wr < 10) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            wa = w && (q.size() < 4 || r);
            if (r && q.size() > 0) begin
                n_cmp++;
                if (bus.rd !== 8'(next_rd)) begin
                    n_bad++;
                    $display("FAIL stream_order: rd=%h, required %h", bus.rd, 8'(next_rd));
                end
                next_rd++;
            end
            step(w, 8'(next_wr), r);
            if (wa) next_wr++;
            n_cmp++;
            if (bus.count !== 3'(q.size()) || bus.rd !== m_head() || bus.count > 3'd4 ||
                bus.empty !== (q.size() == 0) || bus.full !== (q.size() == 4)) begin
                n_bad++;
                $display("FAIL stream_state cyc%0d: count=%0d rd=%h empty=%b full=%b, required %0d %h %b %b",
                         cyc, bus.count, bus.rd, bus.empty, bus.full, q.size(), m_head(),
                         q.size() == 0, q.size() == 4);
            end
            cyc++;
        end
        n_cmp++;
        if (next_rd != 10) begin
            n_bad++;
            $display("FAIL stream_timeout: read %0d words, required 10", next_rd);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
        n_cmp++;
        if (bus.count !== 3'd3) begin
            n_bad++;
            $display("FAIL pre_reset: count=%0d, required 3", bus.count);
        end
        #2;
        rst = 1'b0;
        q.delete();
`ifdef SM_FIFO_ERR_EN
        m_err = 1'b0;
`endif
        #1;
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 3'd0 || bus.rd !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset: empty=%b full=%b count=%0d rd=%h, required 1 0 0 00",
                     bus.empty, bus.full, bus.count, bus.rd);
        end
`ifdef SM_FIFO_ERR_EN
        n_cmp++;
        if (bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_err: err=%b, required 0", bus.err);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        n_cmp++;
        if (bus.rd !== 8'h77 || bus.count !== 3'd1) begin
            n_bad++;
            $display("FAIL post_reset: rd=%h count=%0d, required 77 1", bus.rd, bus.count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw_and_drops();
        test_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
